ysyx_23060286_ctrl_fsm: RTL and testbench
=========================================

# ysyx_23060286_ctrl_fsm

Multicycle control sequencer for the ysyx_23060286 core. It fetches one instruction at a time over a valid handshake and holds it in an instruction register. It decodes the opcode into the immediate-type select consumed by the immediate generator, then steps the datapath through decode, execute, optional memory access and writeback. It sits between the IFU/LSU memory ports and the register file / PC / immediate-generator datapath.

## Interface
- No parameters. The immediate-type encoding is fixed: I=3'b100, S=3'b101, B=3'b011, U=3'b001, J=3'b010, none=3'b000.
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifu_arvalid  out  1  fetch request; high exactly while in FETCH.
- ifu_rvalid  in  1  fetch data valid; sampled only in FETCH.
- ifu_rdata  in  32  fetched instruction.
- lsu_valid  out  1  memory request; high exactly while in MEM.
- lsu_wen  out  1  store select; valid while lsu_valid is high.
- lsu_done  in  1  memory access complete; sampled only in MEM.
- ir  out  32  instruction register; drives the immediate generator's inst[31:7].
- immtype  out  3  registered immediate-type select.
- rf_we  out  1  register-file write strobe; one-cycle pulse in WB.
- pc_we  out  1  PC update strobe; one-cycle pulse in WB.
- halted  out  1  sticky; core stopped.
- illegal  out  1  sticky; stop caused by an unknown opcode.
- retired  out  32  retired-instruction counter.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Reset state is IDLE.
- IDLE -> FETCH unconditionally on the next edge.
- FETCH: ifu_arvalid=1.
  - On an edge with ifu_rvalid=1: ir<=ifu_rdata, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: the opcode ir[6:0] sets immtype on this edge. The same edge leaves DECODE.
  - 0110111/0010111 (LUI/AUIPC) -> U.
  - 1101111 (JAL) -> J.
  - 1100111 (JALR), 0000011 (LOAD), 0010011 (OP-IMM), 1110011 (SYSTEM) -> I.
  - 1100011 (BRANCH) -> B.
  - 0100011 (STORE) -> S.
  - 0110011 (OP) -> none.
  - Any other opcode -> illegal<=1, halted<=1, go to HALT; immtype<=000.
  - SYSTEM with ir==32'h00100073 (ebreak) -> halted<=1, go to HALT.
  - Other SYSTEM encodings are treated as a NOP and sequence normally.
- EXEC: one cycle.
  - LOAD/STORE -> MEM.
  - Everything else -> WB.
- MEM: lsu_valid=1; lsu_wen=1 for STORE, 0 for LOAD.
  - Stay in MEM until an edge with lsu_done=1, then go to WB.
- WB: pc_we=1 for one cycle.
  - rf_we=1 except for STORE, BRANCH and SYSTEM-NOP.
  - retired<=retired+1, modulo 2^32 (wraps 0xFFFFFFFF -> 0).
  - Then go to FETCH.
- HALT: absorbing. All strobes stay 0 and ifu_arvalid stays 0. Only rst exits it.
- Stray inputs are ignored: ifu_rvalid outside FETCH, lsu_done outside MEM.

## Timing
- Reset values, applied immediately on rst, with no clock needed:
  - state=IDLE, ir=0, immtype=000, retired=0, halted=0, illegal=0.
  - ifu_arvalid, lsu_valid, lsu_wen, rf_we and pc_we all 0.
- Strobes and request outputs are decoded from the current state (Moore outputs). They are glitch-free relative to the registered state.
- Minimum latency per non-memory instruction is 4 cycles (FETCH, DECODE, EXEC, WB), with ifu_rvalid high in the first FETCH cycle.
- Loads and stores take 5 cycles minimum. lsu_done high in the first MEM cycle gives a 1-cycle MEM.
- Each extra cycle that rvalid or done is withheld adds one cycle.
- immtype and ir are stable from the edge leaving DECODE until the edge where the next ifu_rvalid is accepted.
- Reset asserted mid-operation (any state, including MEM with lsu_valid high):
  - All outputs drop to their reset values asynchronously.
  - The in-flight instruction is not retired.
  - Sequencing restarts at IDLE.

## Test plan
- Reset: hold rst for 3 cycles, asserting ifu_rvalid and lsu_done at random -> all outputs stay at reset values. After release: IDLE for 1 cycle, then ifu_arvalid=1.
- ADDI 32'h00500093, ifu_rvalid delayed 2 cycles in FETCH:
  - ir=00500093 and immtype=100.
  - rf_we and pc_we pulse together for exactly 1 cycle, 3 cycles after rvalid is accepted.
  - retired=1.
- SW 32'h00112223 with lsu_done delayed 3 cycles:
  - immtype=101, lsu_wen=1, lsu_valid high for 4 cycles.
  - rf_we stays 0 and pc_we pulses once.
- BEQ 32'h00000463 then JAL 32'h008000EF: immtype=011 then 010. The first WB has rf_we=0, the second rf_we=1. retired increments by 2.
- ebreak 32'h00100073 -> halted=1, illegal=0, state HALT. Further ifu_rvalid pulses produce no ifu_arvalid or strobes. Opcode 32'h0000007F -> halted=1, illegal=1, immtype=000.
- Preload retired to 0xFFFFFFFF via a forced sequence (or 2^32-1 retirements in a fast-sim model), then retire one ADDI -> retired=0. Assert rst while in MEM -> lsu_valid drops the same cycle, and retired is not incremented.

Source files
------------

// File: rtl/ysyx_23060286_ctrl_fsm_if.sv
// Handshake and datapath-control bundle between the multicycle sequencer and
// the IFU/LSU memory ports plus register-file / PC / immediate-generator datapath.
interface ysyx_23060286_ctrl_fsm_if;
  logic        ifu_arvalid;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic        lsu_valid;
  logic        lsu_wen;
  logic        lsu_done;
  logic [31:0] ir;
  logic [2:0]  immtype;
  logic        rf_we;
  logic        pc_we;
  logic        halted;
  logic        illegal;
  logic [31:0] retired;

  // Sequencer side
  modport master (
    output ifu_arvalid,
    input  ifu_rvalid,
    input  ifu_rdata,
    output lsu_valid,
    output lsu_wen,
    input  lsu_done,
    output ir,
    output immtype,
    output rf_we,
    output pc_we,
    output halted,
    output illegal,
    output retired
  );

  // Memory / datapath side
  modport slave (
    input  ifu_arvalid,
    output ifu_rvalid,
    output ifu_rdata,
    input  lsu_valid,
    input  lsu_wen,
    output lsu_done,
    input  ir,
    input  immtype,
    input  rf_we,
    input  pc_we,
    input  halted,
    input  illegal,
    input  retired
  );
endinterface

// File: rtl/ysyx_23060286_ctrl_fsm.sv
// Multicycle control sequencer: fetch -> decode -> exec -> (mem) -> writeback,
// with an immediate-type decoder, sticky halt/illegal flags and a retire counter.
module ysyx_23060286_ctrl_fsm (
  input  logic                             clk,
  input  logic                             rst,
  ysyx_23060286_ctrl_fsm_if.master         bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_U    = 3'b001;
  localparam logic [2:0] IMM_J    = 3'b010;
  localparam logic [2:0] IMM_B    = 3'b011;
  localparam logic [2:0] IMM_I    = 3'b100;
  localparam logic [2:0] IMM_S    = 3'b101;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [2:0]  immtype_q, immtype_d;
  logic [31:0] retired_q, retired_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;
  // Instruction class captured in DECODE so later states need not re-decode
  logic        is_mem_q, is_mem_d;
  logic        is_store_q, is_store_d;
  logic        rf_wr_q, rf_wr_d;
  logic        ifu_arvalid_q, ifu_arvalid_d;
  logic        lsu_valid_q, lsu_valid_d;
  logic        lsu_wen_q, lsu_wen_d;
  logic        rf_we_q, rf_we_d;
  logic        pc_we_q, pc_we_d;

  logic [2:0]  dec_imm;
  logic        dec_legal;
  logic        dec_mem;
  logic        dec_store;
  logic        dec_rf;

  always_comb begin
    dec_imm   = IMM_NONE;
    dec_legal = 1'b1;
    dec_mem   = 1'b0;
    dec_store = 1'b0;
    dec_rf    = 1'b1;
    unique case (ir_q[6:0])
      OP_LUI, OP_AUIPC: dec_imm = IMM_U;
      OP_JAL:           dec_imm = IMM_J;
      OP_JALR, OP_IMM:  dec_imm = IMM_I;
      OP_LOAD: begin
        dec_imm = IMM_I;
        dec_mem = 1'b1;
      end
      OP_SYSTEM: begin
        dec_imm = IMM_I;
        dec_rf  = 1'b0;
      end
      OP_BRANCH: begin
        dec_imm = IMM_B;
        dec_rf  = 1'b0;
      end
      OP_STORE: begin
        dec_imm   = IMM_S;
        dec_mem   = 1'b1;
        dec_store = 1'b1;
        dec_rf    = 1'b0;
      end
      OP_OP:   dec_imm = IMM_NONE;
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    immtype_d  = immtype_q;
    retired_d  = retired_q;
    halted_d   = halted_q;
    illegal_d  = illegal_q;
    is_mem_d   = is_mem_q;
    is_store_d = is_store_q;
    rf_wr_d    = rf_wr_q;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.ifu_rvalid) begin
          ir_d    = bus.ifu_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        immtype_d  = dec_imm;
        is_mem_d   = dec_mem;
        is_store_d = dec_store;
        rf_wr_d    = dec_rf;
        if (!dec_legal) begin
          illegal_d = 1'b1;
          halted_d  = 1'b1;
          state_d   = S_HALT;
        end else if (ir_q == INST_EBREAK) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = is_mem_q ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.lsu_done) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        retired_d = retired_q + 32'd1;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Moore outputs are computed from the next state so the flops hold
    // exactly the decode of the registered state, with no output glitches.
    ifu_arvalid_d = (state_d == S_FETCH);
    lsu_valid_d   = (state_d == S_MEM);
    lsu_wen_d     = (state_d == S_MEM) && is_store_d;
    rf_we_d       = (state_d == S_WB) && rf_wr_d;
    pc_we_d       = (state_d == S_WB);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ir_q          <= 32'd0;
      immtype_q     <= IMM_NONE;
      retired_q     <= 32'd0;
      halted_q      <= 1'b0;
      illegal_q     <= 1'b0;
      is_mem_q      <= 1'b0;
      is_store_q    <= 1'b0;
      rf_wr_q       <= 1'b0;
      ifu_arvalid_q <= 1'b0;
      lsu_valid_q   <= 1'b0;
      lsu_wen_q     <= 1'b0;
      rf_we_q       <= 1'b0;
      pc_we_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      immtype_q     <= immtype_d;
      retired_q     <= retired_d;
      halted_q      <= halted_d;
      illegal_q     <= illegal_d;
      is_mem_q      <= is_mem_d;
      is_store_q    <= is_store_d;
      rf_wr_q       <= rf_wr_d;
      ifu_arvalid_q <= ifu_arvalid_d;
      lsu_valid_q   <= lsu_valid_d;
      lsu_wen_q     <= lsu_wen_d;
      rf_we_q       <= rf_we_d;
      pc_we_q       <= pc_we_d;
    end
  end

  assign bus.ifu_arvalid = ifu_arvalid_q;
  assign bus.lsu_valid   = lsu_valid_q;
  assign bus.lsu_wen     = lsu_wen_q;
  assign bus.ir          = ir_q;
  assign bus.immtype     = immtype_q;
  assign bus.rf_we       = rf_we_q;
  assign bus.pc_we       = pc_we_q;
  assign bus.halted      = halted_q;
  assign bus.illegal     = illegal_q;
  assign bus.retired     = retired_q;

endmodule

// File: tb/tb_ysyx_23060286_ctrl_fsm.sv
// Randomized self-checking bench for the multicycle sequencer; a transaction-level
// model predicts each instruction's decode, timeline, strobes and retire count.
module tb_ysyx_23060286_ctrl_fsm;
  logic clk;
  logic rst;

  ysyx_23060286_ctrl_fsm_if bus();

  ysyx_23060286_ctrl_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] imm;
    logic       halt;
    logic       ill;
    logic       mem;
    logic       store;
    logic       rf;
  } exp_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_ret;
  logic [31:0] ins;
  logic [6:0]  ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03,
                            7'h13, 7'h73, 7'h63, 7'h23, 7'h33};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected behaviour of one instruction, straight from the opcode table
  function automatic exp_t predict(input logic [31:0] i);
    exp_t e;
    e.imm = 3'b000; e.halt = 1'b0; e.ill = 1'b0;
    e.mem = 1'b0; e.store = 1'b0; e.rf = 1'b1;
    case (i[6:0])
      7'h37, 7'h17: e.imm = 3'b001;
      7'h6F:        e.imm = 3'b010;
      7'h67, 7'h13: e.imm = 3'b100;
      7'h03: begin e.imm = 3'b100; e.mem = 1'b1; end
      7'h73: begin e.imm = 3'b100; e.rf = 1'b0; e.halt = (i == 32'h0010_0073); end
      7'h63: begin e.imm = 3'b011; e.rf = 1'b0; end
      7'h23: begin e.imm = 3'b101; e.mem = 1'b1; e.store = 1'b1; e.rf = 1'b0; end
      7'h33: e.imm = 3'b000;
      default: begin e.halt = 1'b1; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic stray();
    bus.ifu_rvalid = 1'($urandom);
    bus.ifu_rdata  = $urandom;
    bus.lsu_done   = 1'($urandom);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_arvalid"}, bus.ifu_arvalid, 0);
    check({tag, "_lsu"}, {bus.lsu_valid, bus.lsu_wen}, 0);
    check({tag, "_strobes"}, {bus.rf_we, bus.pc_we}, 0);
    check({tag, "_flags"}, {bus.halted, bus.illegal}, 0);
    check({tag, "_ir"}, bus.ir, 0);
    check({tag, "_immtype"}, bus.immtype, 0);
    check({tag, "_retired"}, bus.retired, 0);
  endtask

  task automatic do_reset(input int cyc);
    @(negedge clk);
    rst = 1'b1;
    #1 check_reset("rst_async");
    for (int i = 0; i < cyc; i++) begin
      stray();
      @(negedge clk);
      check_reset("rst_hold");
    end
    bus.ifu_rvalid = 1'b0;
    bus.lsu_done   = 1'b0;
    rst = 1'b0;
    model_ret = 32'd0;
    check("idle_arvalid", bus.ifu_arvalid, 0);
    @(negedge clk);
    check("first_fetch", bus.ifu_arvalid, 1);
  endtask

  // Runs one instruction through the sequencer from a negedge in FETCH/IDLE
  task automatic run_instr(input logic [31:0] inst, input int fd, input int md);
    exp_t e;
    int   n;
    e = predict(inst);
    n = 0;
    while (bus.ifu_arvalid !== 1'b1 && n < 8) begin
      stray();
      @(negedge clk);
      n++;
    end
    check("fetch_req", bus.ifu_arvalid, 1);
    for (int k = 0; k < fd; k++) begin
      bus.ifu_rvalid = 1'b0;
      bus.ifu_rdata  = $urandom;
      bus.lsu_done   = 1'($urandom);
      @(negedge clk);
      check("fetch_wait", bus.ifu_arvalid, 1);
    end
    bus.ifu_rvalid = 1'b1;
    bus.ifu_rdata  = inst;
    bus.lsu_done   = 1'($urandom);
    @(negedge clk);
    check("ir", bus.ir, inst);
    check("decode_quiet", {bus.ifu_arvalid, bus.lsu_valid, bus.pc_we, bus.rf_we}, 0);
    stray();
    @(negedge clk);
    check("immtype", bus.immtype, e.imm);
    check("halted", bus.halted, e.halt);
    check("illegal", bus.illegal, e.ill);
    if (e.halt) begin
      for (int k = 0; k < 4; k++) begin
        stray();
        @(negedge clk);
        check("halt_quiet", {bus.ifu_arvalid, bus.lsu_valid, bus.pc_we, bus.rf_we}, 0);
        check("halt_sticky", {bus.halted, bus.illegal}, {1'b1, e.ill});
        check("halt_retired", bus.retired, model_ret);
      end
      $display("instr %08h halted illegal=%0d immtype=%03b", inst, e.ill, e.imm);
      return;
    end
    check("exec_quiet", {bus.ifu_arvalid, bus.lsu_valid, bus.pc_we, bus.rf_we}, 0);
    stray();
    @(negedge clk);
    if (e.mem) begin
      for (int k = 0; k <= md; k++) begin
        check("mem_valid", bus.lsu_valid, 1);
        check("mem_wen", bus.lsu_wen, e.store);
        check("mem_no_wb", {bus.pc_we, bus.rf_we}, 0);
        bus.ifu_rvalid = 1'($urandom);
        bus.lsu_done   = (k == md);
        @(negedge clk);
      end
    end
    check("wb_pc_we", bus.pc_we, 1);
    check("wb_rf_we", bus.rf_we, e.rf);
    check("wb_lsu_idle", bus.lsu_valid, 0);
    check("wb_retired_old", bus.retired, model_ret);
    model_ret = model_ret + 32'd1;
    stray();
    @(negedge clk);
    check("post_wb_strobes", {bus.pc_we, bus.rf_we}, 0);
    check("retired", bus.retired, model_ret);
    check("refetch", bus.ifu_arvalid, 1);
    check("ir_stable", bus.ir, inst);
    $display("instr %08h immtype=%03b fetch_wait=%0d mem_wait=%0d retired=%0d",
             inst, e.imm, fd, e.mem ? md : 0, model_ret);
  endtask

  initial begin
    rst = 1'b1;
    bus.ifu_rvalid = 1'b0;
    bus.ifu_rdata  = 32'd0;
    bus.lsu_done   = 1'b0;
    model_ret      = 32'd0;

    do_reset(3);
    run_instr(32'h0050_0093, 2, 0);  // ADDI
    run_instr(32'h0011_2223, 0, 3);  // SW
    run_instr(32'h0000_0463, 0, 0);  // BEQ
    run_instr(32'h0080_00EF, 0, 0);  // JAL
    run_instr(32'h0000_2083, 1, 0);  // LW
    run_instr(32'h0000_0073, 0, 0);  // ECALL as SYSTEM nop

    for (int t = 0; t < 40; t++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 9)];
      if (ins == 32'h0010_0073) ins[20] = 1'b0;
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Counter wrap: hold a preload across one FETCH edge
    bus.ifu_rvalid = 1'b0;
    force dut.retired_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.retired_q;
    model_ret = 32'hFFFF_FFFF;
    check("preload", bus.retired, model_ret);
    run_instr(32'h0050_0093, 0, 0);

    run_instr(32'h0010_0073, 1, 0);  // EBREAK
    do_reset(3);
    run_instr(32'h0000_007F, 0, 0);  // unknown opcode

    // Reset while a store is in MEM
    do_reset(2);
    run_instr(32'h0050_0093, 0, 0);
    bus.ifu_rvalid = 1'b1;
    bus.ifu_rdata  = 32'h0011_2223;
    bus.lsu_done   = 1'b0;
    @(negedge clk);
    bus.ifu_rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_mem", bus.lsu_valid, 1);
    check("pre_rst_retired", bus.retired, model_ret);
    #2 rst = 1'b1;
    #1 check_reset("mem_rst");
    @(negedge clk);
    rst = 1'b0;
    model_ret = 32'd0;
    check("mem_rst_idle", bus.ifu_arvalid, 0);
    @(negedge clk);
    run_instr(32'h0050_0093, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
